reu_dma_seq: RTL

DMA sequencer for the REU. It turns a programmed transfer (stash, fetch, swap, verify) into a per-PHI2-cycle stream of RDCMD/WRCMD/A requests for the SDRAM controller, plus matching C64-bus read/write strobes and addresses. It sits between the register file, which supplies the base values and the START pulse, and the SDRAM controller / C64 bus drivers. It owns address incrementing, length counting, autoload, and verify-error detection.

---
 rtl/reu_dma_seq.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/reu_dma_seq.sv
`default_nettype none
// ============================================================================
// Module  : reu_dma_seq
// Brief   : REU DMA sequencer; turns a programmed stash/fetch/swap/verify
//           transfer into per-PHI2 SDRAM and C64-bus request strobes.
// Revision: 1.0
// ============================================================================
module reu_dma_seq #(
    parameter int REU_AW = 24
) (
    input  logic              C8M,
    input  logic              RESET,
    input  logic              CYC,
    input  logic              BA,
    input  logic              START,
    input  logic [1:0]        TYPE,
    input  logic              FIXC,
    input  logic              FIXR,
    input  logic              AUTOLOAD,
    input  logic [15:0]       C64A_BASE,
    input  logic [REU_AW-1:0] REUA_BASE,
    input  logic [15:0]       LEN_BASE,
    input  logic [7:0]        C64D,
    input  logic [7:0]        RDD,
    output logic              nDMA,
    output logic              RDCMD,
    output logic              WRCMD,
    output logic [REU_AW-1:0] A,
    output logic [15:0]       C64A,
    output logic              C64RD,
    output logic              C64WR,
    output logic [7:0]        SWAPD,
    output logic              BUSY,
    output logic              EOB,
    output logic              VERR,
    output logic [15:0]       LEN
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_XFER  = 3'd2;
    localparam logic [2:0] S_SWAP2 = 3'd3;
    localparam logic [2:0] S_FIN   = 3'd4;

    localparam logic [1:0] T_STASH  = 2'b00;
    localparam logic [1:0] T_FETCH  = 2'b01;
    localparam logic [1:0] T_SWAP   = 2'b10;
    localparam logic [1:0] T_VERIFY = 2'b11;

    // Strobe vector order: {RDCMD, WRCMD, C64RD, C64WR}
    localparam logic [3:0] c_STRB_NONE  = 4'b0000;
    localparam logic [3:0] c_STRB_SWAPW = 4'b0101;

    logic [2:0]        state_q, state_d;
    logic [REU_AW-1:0] a_q, a_d;
    logic [15:0]       c64a_q, c64a_d;
    logic [15:0]       len_q, len_d;
    logic [7:0]        swapd_q, swapd_d;
    logic [3:0]        strb_q, strb_d;
    logic              ndma_q, ndma_d;
    logic              busy_q, busy_d;
    logic              eob_q, eob_d;
    logic              verr_q, verr_d;
    logic              stall_q, stall_d;

    logic              w_go;
    logic              w_last;
    logic              w_mism;
    logic              w_complete;
    logic [3:0]        w_p1;

    assign w_go   = CYC & BA;
    assign w_last = (len_q == 16'd1);
    assign w_mism = (TYPE == T_VERIFY) && (C64D != RDD);

    // A byte completes when its final command was held for a full, un-stalled PHI2 period
    assign w_complete = w_go && !stall_q &&
                        (((state_q == S_XFER) && (TYPE != T_SWAP)) || (state_q == S_SWAP2));

    always_comb begin
        unique case (TYPE)
            T_STASH:  w_p1 = 4'b0110;
            T_FETCH:  w_p1 = 4'b1001;
            default:  w_p1 = 4'b1010;
        endcase
    end

    always_ff @(posedge C8M or posedge RESET) begin
        if (RESET) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            c64a_q  <= 16'h0000;
            len_q   <= 16'h0000;
            swapd_q <= 8'h00;
            strb_q  <= c_STRB_NONE;
            ndma_q  <= 1'b1;
            busy_q  <= 1'b0;
            eob_q   <= 1'b0;
            verr_q  <= 1'b0;
            stall_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            c64a_q  <= c64a_d;
            len_q   <= len_d;
            swapd_q <= swapd_d;
            strb_q  <= strb_d;
            ndma_q  <= ndma_d;
            busy_q  <= busy_d;
            eob_q   <= eob_d;
            verr_q  <= verr_d;
            stall_q <= stall_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (START) state_d = S_REQ;
            S_REQ:   if (w_go) state_d = S_XFER;
            S_XFER: begin
                if (w_go && !stall_q) begin
                    if (TYPE == T_SWAP)       state_d = S_SWAP2;
                    else if (w_last || w_mism) state_d = S_FIN;
                end
            end
            S_SWAP2: if (w_go && !stall_q) state_d = w_last ? S_FIN : S_XFER;
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        a_d     = a_q;
        c64a_d  = c64a_q;
        len_d   = len_q;
        swapd_d = swapd_q;
        strb_d  = strb_q;
        ndma_d  = ndma_q;
        busy_d  = busy_q;
        eob_d   = eob_q;
        verr_d  = verr_q;
        stall_d = stall_q;

        // The final byte keeps LEN at 1 so software sees a completed block
        if (w_complete) begin
            a_d    = FIXR ? a_q : a_q + REU_AW'(1);
            c64a_d = FIXC ? c64a_q : c64a_q + 16'd1;
            if (!w_last) len_d = len_q - 16'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (START) begin
                    a_d     = REUA_BASE;
                    c64a_d  = C64A_BASE;
                    len_d   = LEN_BASE;
                    eob_d   = 1'b0;
                    verr_d  = 1'b0;
                    busy_d  = 1'b1;
                    ndma_d  = 1'b0;
                    stall_d = 1'b0;
                    strb_d  = c_STRB_NONE;
                end
            end
            S_REQ: begin
                if (CYC) strb_d = BA ? w_p1 : c_STRB_NONE;
            end
            S_XFER: begin
                if (CYC) begin
                    if (!BA) begin
                        strb_d  = c_STRB_NONE;
                        stall_d = 1'b1;
                    end else if (stall_q) begin
                        strb_d  = w_p1;
                        stall_d = 1'b0;
                    end else if (TYPE == T_SWAP) begin
                        swapd_d = RDD;
                        strb_d  = c_STRB_SWAPW;
                    end else if (w_last || w_mism) begin
                        strb_d = c_STRB_NONE;
                        ndma_d = 1'b1;
                        busy_d = 1'b0;
                        eob_d  = w_last;
                        verr_d = w_mism;
                    end else begin
                        strb_d = w_p1;
                    end
                end
            end
            S_SWAP2: begin
                if (CYC) begin
                    if (!BA) begin
                        strb_d  = c_STRB_NONE;
                        stall_d = 1'b1;
                    end else if (stall_q) begin
                        strb_d  = c_STRB_SWAPW;
                        stall_d = 1'b0;
                    end else if (w_last) begin
                        strb_d = c_STRB_NONE;
                        ndma_d = 1'b1;
                        busy_d = 1'b0;
                        eob_d  = 1'b1;
                    end else begin
                        strb_d = w_p1;
                    end
                end
            end
            S_FIN: begin
                if (AUTOLOAD) begin
                    a_d    = REUA_BASE;
                    c64a_d = C64A_BASE;
                    len_d  = LEN_BASE;
                end
            end
            default: ;
        endcase
    end

    assign nDMA  = ndma_q;
    assign RDCMD = strb_q[3];
    assign WRCMD = strb_q[2];
    assign C64RD = strb_q[1];
    assign C64WR = strb_q[0];
    assign A     = a_q;
    assign C64A  = c64a_q;
    assign LEN   = len_q;
    assign SWAPD = swapd_q;
    assign BUSY  = busy_q;
    assign EOB   = eob_q;
    assign VERR  = verr_q;

endmodule
`default_nettype wire
